root_fanout_dispatcher: RTL and testbench

- Upstream feeder stage for a root node and its five child instances (inst_0..inst_4).
- Accepts one stream of work items, buffers them in a small FIFO, and deals them to the children in strict round-robin order over per-child valid/ready lanes.
- Skips lanes disabled by a run-time mask.
- Single clock domain; synchronous active-high reset.

---
 rtl/root_fanout_dispatcher_if.sv | 47 ++++
 rtl/root_fanout_dispatcher.sv | 138 +++++++++++++
 tb/tb_root_fanout_dispatcher.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/root_fanout_dispatcher_if.sv
// Signal bundle for root_fanout_dispatcher: upstream stream, per-child lanes and status.
// slave = the dispatcher itself, master = the feeder/consumer environment around it.
// Defining ROOT_DISPATCH_STATS_EN adds the lane_cnt/stall_cnt statistics outputs.
interface root_fanout_dispatcher_if #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4
) ();
  localparam int LANE_W = $clog2(NUM_CHILD);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_W-1:0]    s_data;
  logic [NUM_CHILD-1:0] lane_en;
  logic [NUM_CHILD-1:0] m_valid;
  logic [NUM_CHILD-1:0] m_ready;
  logic [DATA_W-1:0]    m_data;
  logic [LANE_W-1:0]    cur_lane;
  logic [FILL_W-1:0]    fill;
  logic                 idle;

`ifdef ROOT_DISPATCH_STATS_EN
  logic [NUM_CHILD*16-1:0] lane_cnt;
  logic [15:0]             stall_cnt;

  modport master (
    output s_valid, s_data, lane_en, m_ready,
    input  s_ready, m_valid, m_data, cur_lane, fill, idle, lane_cnt, stall_cnt
  );

  modport slave (
    input  s_valid, s_data, lane_en, m_ready,
    output s_ready, m_valid, m_data, cur_lane, fill, idle, lane_cnt, stall_cnt
  );
`else
  modport master (
    output s_valid, s_data, lane_en, m_ready,
    input  s_ready, m_valid, m_data, cur_lane, fill, idle
  );

  modport slave (
    input  s_valid, s_data, lane_en, m_ready,
    output s_ready, m_valid, m_data, cur_lane, fill, idle
  );
`endif
endinterface

// File: rtl/root_fanout_dispatcher.sv
// Buffers one work-item stream in a small FIFO and deals items round-robin to enabled child lanes.
// Optional statistics (per-lane transfer counters, stall counter) are built when ROOT_DISPATCH_STATS_EN is defined.
module root_fanout_dispatcher #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  root_fanout_dispatcher_if.slave bus
);
  localparam int LANE_W = $clog2(NUM_CHILD);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int FILL_W = ADDR_W + 1;

  // Lane selector: SEL holds cur_lane, ADV marks a cycle whose edge loads the searched lane.
  localparam logic [0:0] SEL = 1'b0;
  localparam logic [0:0] ADV = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [FILL_W-1:0] fill_q;
  logic [DATA_W-1:0] hold_q;
  logic [LANE_W-1:0] cur_q;
  logic [LANE_W-1:0] next_lane;
  logic              locked_q;
  logic [0:0]        lane_mode;

  logic has_item;
  logic cur_en;
  logic valid_any;
  logic s_ready_int;
  logic push;
  logic pop;

  // First enabled lane after 'from', cyclically; 'from' itself is checked last, and held if none is enabled.
  function automatic logic [LANE_W-1:0] search_next(
    input logic [NUM_CHILD-1:0] en,
    input logic [LANE_W-1:0]    from
  );
    logic [LANE_W-1:0] idx;
    logic [LANE_W-1:0] res;
    logic              found;
    idx   = from;
    res   = from;
    found = 1'b0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      idx = (idx == LANE_W'(NUM_CHILD - 1)) ? '0 : idx + 1'b1;
      if (!found && en[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // A lane offered an item keeps it (locked_q) even if its enable drops before the handshake.
  assign has_item    = (fill_q != '0);
  assign cur_en      = bus.lane_en[cur_q];
  assign valid_any   = has_item & (cur_en | locked_q) & ~rst;
  assign s_ready_int = ~rst & (fill_q < FILL_W'(DEPTH));
  assign push        = bus.s_valid & s_ready_int;
  assign pop         = valid_any & bus.m_ready[cur_q];

  assign next_lane = search_next(bus.lane_en, cur_q);
  assign lane_mode = (pop | (~locked_q & ~cur_en)) ? ADV : SEL;

  always_comb begin
    // NOTE: the vector gets a full default before the indexed write, so no latch is inferred.
    bus.m_valid        = '0;
    bus.m_valid[cur_q] = valid_any;
  end

  assign bus.s_ready  = s_ready_int;
  assign bus.m_data   = has_item ? mem[rd_ptr] : hold_q;
  assign bus.cur_lane = cur_q;
  assign bus.fill     = fill_q;
  assign bus.idle     = ~has_item;

  // NOTE: storage array is not reset; fill/pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.s_data;
  end

  // NOTE: all state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_q   <= '0;
      hold_q   <= '0;
      cur_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
      if (lane_mode == ADV) cur_q <= next_lane;
      locked_q <= valid_any & ~pop;
    end
  end

`ifdef ROOT_DISPATCH_STATS_EN
  logic [NUM_CHILD*16-1:0] lane_cnt_q;
  logic [15:0]             stall_q;

  // Per-lane counters wrap naturally; the stall counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt_q <= '0;
      stall_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CHILD; i++) begin
        if (pop && (cur_q == LANE_W'(i)))
          lane_cnt_q[i*16 +: 16] <= lane_cnt_q[i*16 +: 16] + 16'd1;
      end
      if (valid_any && !bus.m_ready[cur_q] && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.lane_cnt  = lane_cnt_q;
  assign bus.stall_cnt = stall_q;
`endif

  a_onehot: assert property (@(posedge clk) $onehot0(bus.m_valid));
  a_fill_bound: assert property (@(posedge clk) disable iff (rst) fill_q <= FILL_W'(DEPTH));
  a_offer_stable: assert property (@(posedge clk) disable iff (rst)
    (valid_any && !pop) |=> (valid_any && $stable(cur_q) && $stable(bus.m_data)));
endmodule

// File: tb/tb_root_fanout_dispatcher.sv
// Self-checking bench for root_fanout_dispatcher: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a queue-based behavioural model.
module tb_root_fanout_dispatcher;
  localparam int N     = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   odd_seen = 0;

  always #5 clk = ~clk;

  root_fanout_dispatcher_if #(.NUM_CHILD(N), .DATA_W(DW), .DEPTH(DEPTH)) bus ();

  root_fanout_dispatcher #(.NUM_CHILD(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model: item queue, target lane, "offer outstanding" flag, last delivered item.
  logic [DW-1:0] mq[$];
  logic [LW-1:0] mcur  = '0;
  bit            mpend = 1'b0;
  logic [DW-1:0] mlast = '0;
  logic [15:0]   mcnt [N];
  logic [15:0]   mstall = '0;

  logic [39:0] mdl_log[$];
  logic [39:0] dut_log[$];
  logic [39:0] exp_log[$];
  int          dut_stamp[$];

  initial foreach (mcnt[i]) mcnt[i] = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] next_en(input logic [LW-1:0] from, input logic [N-1:0] en);
    logic [LW-1:0] l;
    for (int k = 1; k <= N; k++) begin
      l = LW'((int'(from) + k) % N);
      if (en[l]) return l;
    end
    return from;
  endfunction

  task automatic model_step();
    bit offer, xfer, push;
    if (rst) begin
      mq.delete();
      mcur = '0; mpend = 1'b0; mlast = '0; mstall = '0;
      foreach (mcnt[i]) mcnt[i] = '0;
      return;
    end
    offer = (mq.size() != 0) && (bus.lane_en[mcur] || mpend);
    xfer  = offer && bus.m_ready[mcur];
    push  = bus.s_valid && (mq.size() < DEPTH);
    if (offer && !bus.m_ready[mcur] && (mstall != 16'hFFFF)) mstall = mstall + 16'd1;
    if (xfer) begin
      mlast = mq.pop_front();
      mdl_log.push_back({8'(mcur), mlast});
      mcnt[mcur] = mcnt[mcur] + 16'd1;
      mcur = next_en(mcur, bus.lane_en);
    end else if (!mpend && !bus.lane_en[mcur]) begin
      mcur = next_en(mcur, bus.lane_en);
    end
    mpend = offer && !xfer;
    if (push) mq.push_back(bus.s_data);
  endtask

  always @(posedge clk) model_step();

  // Single compare process: outputs settle well after the negedge input update.
  always @(negedge clk) begin
    logic [N-1:0]  exp_v;
    logic [N-1:0]  hs;
    logic [LW-1:0] hl;
    bit            offer;
    #2;
    cyc++;
    offer = !rst && (mq.size() != 0) && (bus.lane_en[mcur] || mpend);
    exp_v = offer ? (N'(1) << mcur) : '0;
    check("m_valid",  bus.m_valid,  exp_v);
    check("m_data",   bus.m_data,   (mq.size() != 0) ? mq[0] : mlast);
    check("fill",     bus.fill,     mq.size());
    check("s_ready",  bus.s_ready,  (!rst && (mq.size() < DEPTH)));
    check("cur_lane", bus.cur_lane, mcur);
    check("idle",     bus.idle,     (mq.size() == 0));
`ifdef ROOT_DISPATCH_STATS_EN
    begin
      logic [N*16-1:0] exp_cnt;
      for (int i = 0; i < N; i++) exp_cnt[i*16 +: 16] = mcnt[i];
      check("lane_cnt",  bus.lane_cnt,  exp_cnt);
      check("stall_cnt", bus.stall_cnt, mstall);
    end
`endif
    hs = bus.m_valid & bus.m_ready;
    if (hs != '0) begin
      hl = '0;
      for (int i = 0; i < N; i++) if (hs == (N'(1) << i)) hl = LW'(i);
      dut_log.push_back({8'(hl), bus.m_data});
      dut_stamp.push_back(cyc);
    end
    if (bus.m_valid[1] || bus.m_valid[3]) odd_seen++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    dut_log.delete(); mdl_log.delete(); exp_log.delete(); dut_stamp.delete();
  endtask

  task automatic verify(input string name);
    check($sformatf("%s_count_dut", name), dut_log.size(), exp_log.size());
    check($sformatf("%s_count_model", name), mdl_log.size(), exp_log.size());
    foreach (exp_log[i]) begin
      if (i < dut_log.size()) check($sformatf("%s_dut_%0d", name, i), dut_log[i], exp_log[i]);
      if (i < mdl_log.size()) check($sformatf("%s_model_%0d", name, i), mdl_log[i], exp_log[i]);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEAD_BEEF;
    bus.lane_en = '1;
    bus.m_ready = '0;

    // Reset and idle
    tick(3);
    #3;
    check("rst_s_ready",  bus.s_ready,  1'b0);
    check("rst_m_valid",  bus.m_valid,  5'b00000);
    check("rst_fill",     bus.fill,     3'd0);
    check("rst_cur_lane", bus.cur_lane, 3'd0);
    check("rst_idle",     bus.idle,     1'b1);
    check("rst_m_data",   bus.m_data,   32'h0);
    tick();
    rst = 1'b0;
    bus.s_valid = 1'b0;
    #3;
    check("s_ready_after_rst", bus.s_ready, 1'b1);

    // Round-robin over all lanes
    tick();
    do_reset();
    bus.lane_en = 5'b11111;
    bus.m_ready = 5'b11111;
    clear_logs();
    for (int i = 0; i < 7; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hA0 + 32'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    tick(4);
    for (int i = 0; i < 7; i++) exp_log.push_back({8'(i % 5), 32'hA0 + 32'(i)});
    verify("rr");
    if (dut_stamp.size() == 7) check("rr_back_to_back", dut_stamp[6] - dut_stamp[0], 6);
    else check("rr_stamp_count", dut_stamp.size(), 7);

    // Masked lanes 1 and 3
    do_reset();
    bus.lane_en = 5'b10101;
    clear_logs();
    odd_seen = 0;
    for (int i = 0; i < 6; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hE0 + 32'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    tick(4);
    exp_log.push_back({8'd0, 32'hE0}); exp_log.push_back({8'd2, 32'hE1});
    exp_log.push_back({8'd4, 32'hE2}); exp_log.push_back({8'd0, 32'hE3});
    exp_log.push_back({8'd2, 32'hE4}); exp_log.push_back({8'd4, 32'hE5});
    verify("mask");
    check("mask_odd_lanes_quiet", odd_seen, 0);

    // Back-pressure up to full, then release
    do_reset();
    bus.lane_en = 5'b11111;
    bus.m_ready = 5'b00000;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hB0 + 32'(i);
      tick();
    end
    bus.s_data = 32'hB4;
    tick(3);
    #3;
    check("bp_fill_full",  bus.fill,    3'd4);
    check("bp_s_ready",    bus.s_ready, 1'b0);
    check("bp_m_valid",    bus.m_valid, 5'b00001);
    check("bp_m_data",     bus.m_data,  32'hB0);
    tick();
    bus.m_ready = 5'b11111;
    tick();
    #3;
    check("bp_pop_only_fill", bus.fill,     3'd3);
    check("bp_pop_only_lane", bus.cur_lane, 3'd1);
    check("bp_pop_only_data", bus.m_data,   32'hB1);
    tick();
    bus.s_valid = 1'b0;
    #3;
    check("bp_push_pop_fill", bus.fill,   3'd3);
    check("bp_push_pop_data", bus.m_data, 32'hB2);
    tick(6);
    for (int i = 0; i < 5; i++) exp_log.push_back({8'(i), 32'hB0 + 32'(i)});
    verify("bp");

    // All lanes disabled, then only lane 3
    do_reset();
    bus.lane_en = 5'b00000;
    bus.m_ready = 5'b11111;
    clear_logs();
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hC0;
    tick();
    bus.s_data  = 32'hC1;
    tick();
    bus.s_valid = 1'b0;
    tick(3);
    #3;
    check("off_m_valid",  bus.m_valid,  5'b00000);
    check("off_cur_lane", bus.cur_lane, 3'd0);
    check("off_fill",     bus.fill,     3'd2);
    tick();
    bus.lane_en = 5'b01000;
    tick();
    #3;
    check("lane3_cur_lane", bus.cur_lane, 3'd3);
    check("lane3_m_valid",  bus.m_valid,  5'b01000);
    check("lane3_m_data",   bus.m_data,   32'hC0);
    tick(4);
    exp_log.push_back({8'd3, 32'hC0});
    exp_log.push_back({8'd3, 32'hC1});
    verify("lane3");

    // Reset while lane 2 is being offered with three items buffered
    do_reset();
    bus.lane_en = 5'b11111;
    bus.m_ready = 5'b11111;
    clear_logs();
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hD0;
    tick();
    bus.s_data  = 32'hD1;
    tick();
    bus.s_valid = 1'b0;
    tick();
    bus.m_ready = 5'b00000;
    for (int i = 2; i < 5; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hD0 + 32'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    #3;
    check("mid_pre_fill",    bus.fill,    3'd3);
    check("mid_pre_m_valid", bus.m_valid, 5'b00100);
    tick();
    rst = 1'b1;
    bus.m_ready = 5'b11111;
    tick();
    #3;
    check("mid_rst_fill",     bus.fill,     3'd0);
    check("mid_rst_m_valid",  bus.m_valid,  5'b00000);
    check("mid_rst_cur_lane", bus.cur_lane, 3'd0);
    check("mid_rst_idle",     bus.idle,     1'b1);
`ifdef ROOT_DISPATCH_STATS_EN
    check("mid_rst_lane_cnt", bus.lane_cnt, '0);
`endif
    exp_log.push_back({8'd0, 32'hD0});
    exp_log.push_back({8'd1, 32'hD1});
    verify("mid");
    tick();
    rst = 1'b0;

    // Randomized traffic, including lane_en churn while offers are outstanding
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      bus.s_valid = ($urandom_range(0, 2) != 0);
      bus.s_data  = $urandom;
      if ($urandom_range(0, 7) == 0)
        bus.lane_en = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      bus.m_ready = N'($urandom | $urandom);
      tick();
    end
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.lane_en = 5'b11111;
    bus.m_ready = 5'b11111;
    tick(12);
    #3;
    check("drain_idle", bus.idle, 1'b1);
    check("drain_fill", bus.fill, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
